// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and sample types for the FIR filter datapath
// Purpose: common localparams and sample/result typedefs used by the FIR core
//          and its downstream stages.
// Ports:   none (package).
package fir_pkg;

    localparam int FIR_IN_SAMPLE_WIDTH  = 16;
    localparam int FIR_OUT_SAMPLE_WIDTH = 32;
    localparam int MAX_SAMPLES_NUM      = 8;

    typedef logic signed [FIR_IN_SAMPLE_WIDTH-1:0]  fir_sample_t;
    typedef logic signed [FIR_OUT_SAMPLE_WIDTH-1:0] fir_result_t;

endpackage

// File: rtl/fir_scale_sat.sv
// rtl/fir_scale_sat.sv - combinational scale (shift) and 16-bit saturation of one FIR result
// Purpose: y = sat16(x >>> SHIFT), floor by default; with FIR_OUT_ROUND_EN defined,
//          y = sat16((x + 2^(SHIFT-1)) >>> SHIFT) (round half up).
// Ports:   x  in  32-bit signed filter result
//          y  out 16-bit signed scaled, saturated sample
// Config:  FIR_OUT_ROUND_EN
module fir_scale_sat
    import fir_pkg::*;
#(
    parameter int SHIFT = 15
) (
    input  fir_result_t x,
    output fir_sample_t y
);

    // Half an output LSB; evaluates to zero when SHIFT is 0.
    localparam logic [32:0] ROUND_BIAS = (33'd1 << SHIFT) >> 1;

    // 33 bits so the rounding add on a maximal positive input cannot wrap.
    logic signed [32:0] wide;
    logic signed [32:0] shifted;

    always_comb begin
        wide = {x[31], x};
`ifdef FIR_OUT_ROUND_EN
        wide = wide + $signed(ROUND_BIAS);
`endif
        shifted = wide >>> SHIFT;
        if (shifted > 33'sd32767) begin
            y = 16'sh7FFF;
        end else if (shifted < -33'sd32768) begin
            y = 16'sh8000;
        end else begin
            y = shifted[15:0];
        end
    end

endmodule

// File: rtl/fir_result_serializer.sv
// rtl/fir_result_serializer.sv - ping-pong block buffer that scales FIR results and streams them out
// Purpose: captures a block of SAMPLES_NUM results on doneIn, scales/saturates every lane
//          to 16 bits, and emits the block one lane per valid/ready transfer. Two block
//          buffers absorb backpressure; a block arriving with both full is dropped.
// Ports:   clkIn, nResetIn (async, active-low)
//          doneIn, dataIn[32*SAMPLES_NUM]  block capture from the filter core (lane 0 in MSBs)
//          readyIn                         downstream accepts a sample
//          validOut, dataOut[16], lastOut  output stream, lastOut on the final lane
//          busyOut                         both buffers occupied
//          overflowOut, clearIn            sticky drop flag and its synchronous clear
// Config:  FIR_OUT_ROUND_EN (forwarded to fir_scale_sat)
module fir_result_serializer
    import fir_pkg::*;
#(
    parameter int SAMPLES_NUM = 4,
    parameter int SHIFT       = 15
) (
    input  logic                                      clkIn,
    input  logic                                      nResetIn,
    input  logic                                      doneIn,
    input  logic [FIR_OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] dataIn,
    input  logic                                      readyIn,
    output logic                                      validOut,
    output logic [FIR_IN_SAMPLE_WIDTH-1:0]            dataOut,
    output logic                                      lastOut,
    output logic                                      busyOut,
    output logic                                      overflowOut,
    input  logic                                      clearIn
);

    localparam int LANE_W = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SAMPLES_NUM - 1);

    fir_sample_t scaled [SAMPLES_NUM];
    fir_sample_t buffer [2][SAMPLES_NUM];

    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              wr_ptr;
    logic              wr_nxt;
    logic              rd_ptr;
    logic              rd_nxt;
    logic [LANE_W-1:0] lane_idx;
    logic [LANE_W-1:0] lane_nxt;
    logic              xfer;
    logic              last_xfer;
    logic              capture;
    logic              drop;
    logic              ovf_nxt;
    fir_sample_t       data_nxt;

    for (genvar k = 0; k < SAMPLES_NUM; k++) begin : g_lane
        fir_scale_sat #(
            .SHIFT(SHIFT)
        ) u_scale_sat (
            .x(dataIn[FIR_OUT_SAMPLE_WIDTH*(SAMPLES_NUM-k)-1 -: FIR_OUT_SAMPLE_WIDTH]),
            .y(scaled[k])
        );
    end

    always_comb begin
        xfer      = validOut && readyIn;
        last_xfer = xfer && (lane_idx == LAST_LANE);
        // A last-lane transfer frees its slot on the same edge, so a coincident
        // capture with both buffers full still has somewhere to go.
        capture   = doneIn && ((count != 2'd2) || last_xfer);
        drop      = doneIn && !capture;

        count_nxt = count;
        if (capture && !last_xfer) begin
            count_nxt = count + 2'd1;
        end else if (!capture && last_xfer) begin
            count_nxt = count - 2'd1;
        end

        wr_nxt = wr_ptr ^ capture;
        rd_nxt = rd_ptr ^ last_xfer;

        lane_nxt = lane_idx;
        if (last_xfer) begin
            lane_nxt = '0;
        end else if (xfer) begin
            lane_nxt = lane_idx + 1'b1;
        end

        // Bypass the buffer when the slot being read next is the one written this edge.
        if (capture && (wr_ptr == rd_nxt)) begin
            data_nxt = scaled[lane_nxt];
        end else begin
            data_nxt = buffer[rd_nxt][lane_nxt];
        end

        ovf_nxt = overflowOut;
        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (clearIn) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < SAMPLES_NUM; k++) begin
                    buffer[b][k] <= '0;
                end
            end
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            lane_idx    <= '0;
            validOut    <= 1'b0;
            dataOut     <= '0;
            lastOut     <= 1'b0;
            busyOut     <= 1'b0;
            overflowOut <= 1'b0;
        end else begin
            if (capture) begin
                for (int k = 0; k < SAMPLES_NUM; k++) begin
                    buffer[wr_ptr][k] <= scaled[k];
                end
            end
            count       <= count_nxt;
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            lane_idx    <= lane_nxt;
            validOut    <= (count_nxt != 2'd0);
            dataOut     <= data_nxt;
            lastOut     <= (count_nxt != 2'd0) && (lane_nxt == LAST_LANE);
            busyOut     <= (count_nxt == 2'd2);
            overflowOut <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_fir_result_serializer.sv
// tb/tb_fir_result_serializer.sv - self-checking bench for fir_result_serializer
module tb_fir_result_serializer;

    localparam int N     = 4;
    localparam int SHIFT = 15;

    logic          clk;
    logic          nResetIn;
    logic          doneIn;
    logic [32*N-1:0] dataIn;
    logic          readyIn;
    logic          validOut;
    logic [15:0]   dataOut;
    logic          lastOut;
    logic          busyOut;
    logic          overflowOut;
    logic          clearIn;

    fir_result_serializer #(
        .SAMPLES_NUM(N),
        .SHIFT(SHIFT)
    ) dut (
        .clkIn(clk),
        .nResetIn(nResetIn),
        .doneIn(doneIn),
        .dataIn(dataIn),
        .readyIn(readyIn),
        .validOut(validOut),
        .dataOut(dataOut),
        .lastOut(lastOut),
        .busyOut(busyOut),
        .overflowOut(overflowOut),
        .clearIn(clearIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        bit          last;
    } exp_t;

    exp_t        q[$];
    bit          m_ovf;
    logic [15:0] nxt_exp [N];
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Floor (or round-half-up) division by 2^SHIFT followed by clamping.
    function automatic logic [15:0] ref_scale(input logic [31:0] x);
        longint v, d, r;
        logic [63:0] rv;
        v = longint'($signed(x));
        d = longint'(1) << SHIFT;
`ifdef FIR_OUT_ROUND_EN
        v = v + d / 2;
`endif
        r = v / d;
        if ((v % d) != 0 && v < 0) r = r - 1;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        rv = r;
        return rv[15:0];
    endfunction

    // Checks the outputs against the model for the coming edge, advances the model,
    // then waits for the next falling edge.
    task automatic tick();
        bit valid_e;
        bit last_x;
        int blocks;
        valid_e = (q.size() != 0);
        blocks  = (q.size() + N - 1) / N;
        chk("valid", validOut, valid_e);
        chk("busy", busyOut, blocks == 2);
        chk("overflow", overflowOut, m_ovf);
        if (valid_e) begin
            chk("data", dataOut, q[0].data);
            chk("last", lastOut, q[0].last);
        end
        last_x = valid_e && readyIn && q[0].last;
        if (doneIn) begin
            if (blocks < 2 || last_x) begin
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.data = nxt_exp[k];
                    e.last = (k == N - 1);
                    q.push_back(e);
                end
            end else begin
                m_ovf = 1'b1;
            end
        end else if (clearIn) begin
            m_ovf = 1'b0;
        end
        if (valid_e && readyIn) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic pulse_model(input logic [32*N-1:0] d);
        logic [31:0] lane;
        dataIn = d;
        for (int k = 0; k < N; k++) begin
            lane = d[32*(N-k)-1 -: 32];
            nxt_exp[k] = ref_scale(lane);
        end
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0;
    endtask

    task automatic pulse_exp(input logic [32*N-1:0] d, input logic [63:0] e);
        dataIn = d;
        for (int k = 0; k < N; k++) nxt_exp[k] = e[16*(N-k)-1 -: 16];
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, validOut, 1'b0);
        chk({tag, "_data"}, dataOut, 16'h0000);
        chk({tag, "_last"}, lastOut, 1'b0);
        chk({tag, "_busy"}, busyOut, 1'b0);
        chk({tag, "_overflow"}, overflowOut, 1'b0);
    endtask

    initial begin
        logic [32*N-1:0] rnd;
        checks   = 0;
        failures = 0;
        m_ovf    = 1'b0;
        nResetIn = 1'b0;
        doneIn   = 1'b0;
        dataIn   = '0;
        readyIn  = 1'b0;
        clearIn  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        nResetIn = 1'b1;
        @(negedge clk);

        // Basic block with ready high; latency one cycle from doneIn
        readyIn = 1'b1;
`ifdef FIR_OUT_ROUND_EN
        pulse_exp({32'h00004000, 32'h00008000, 32'hFFFF8000, 32'h7FFFFFFF},
                  {16'h0001, 16'h0001, 16'hFFFF, 16'h7FFF});
`else
        pulse_exp({32'h00004000, 32'h00008000, 32'hFFFF8000, 32'h7FFFFFFF},
                  {16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF});
`endif
        chk("latency_valid", validOut, 1'b1);
        repeat (5) tick();

        // Negative saturation and -1 handling
`ifdef FIR_OUT_ROUND_EN
        pulse_exp({32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00017FFF},
                  {16'h8000, 16'h0000, 16'h0000, 16'h0003});
`else
        pulse_exp({32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00017FFF},
                  {16'h8000, 16'hFFFF, 16'h0000, 16'h0002});
`endif
        repeat (5) tick();

        // Backpressure mid-block holds the output
        pulse_model({32'h00010000, 32'h00020000, 32'hFFFD0000, 32'h00040000});
        tick();
        readyIn = 1'b0;
        repeat (5) tick();
        readyIn = 1'b1;
        repeat (5) tick();

        // Two blocks buffered, third dropped, then clear
        readyIn = 1'b0;
        pulse_model({32'h00110000, 32'h00120000, 32'h00130000, 32'h00140000});
        tick();
        pulse_model({32'h00210000, 32'h00220000, 32'h00230000, 32'h00240000});
        chk("busy_after_two", busyOut, 1'b1);
        tick();
        pulse_model({32'h00310000, 32'h00320000, 32'h00330000, 32'h00340000});
        chk("overflow_set", overflowOut, 1'b1);
        tick();
        readyIn = 1'b1;
        repeat (9) tick();
        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
        chk("overflow_cleared", overflowOut, 1'b0);
        tick();

        // Capture coincident with last-lane transfer while full
        readyIn = 1'b0;
        pulse_model({32'h00410000, 32'h00420000, 32'h00430000, 32'h00440000});
        pulse_model({32'h00510000, 32'h00520000, 32'h00530000, 32'h00540000});
        tick();
        readyIn = 1'b1;
        repeat (3) tick();
        pulse_model({32'h00610000, 32'h00620000, 32'h00630000, 32'h00640000});
        chk("coincident_no_overflow", overflowOut, 1'b0);
        chk("coincident_busy", busyOut, 1'b1);
        repeat (10) tick();

        // Reset mid-stream
        pulse_model({32'h00710000, 32'h00720000, 32'h00730000, 32'h00740000});
        repeat (2) tick();
        #2 nResetIn = 1'b0;
        #1 check_zero_outputs("midreset");
        q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        nResetIn = 1'b1;
        repeat (4) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            readyIn = ($urandom_range(0, 3) != 0);
            clearIn = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < N; k++) begin
                    case ($urandom_range(0, 4))
                        0:       rnd[32*k +: 32] = 32'h80000000;
                        1:       rnd[32*k +: 32] = 32'h7FFFFFFF;
                        2:       rnd[32*k +: 32] = $urandom_range(0, 65535) - 32768;
                        default: rnd[32*k +: 32] = $urandom;
                    endcase
                end
                pulse_model(rnd);
            end else begin
                tick();
            end
        end
        readyIn = 1'b1;
        clearIn = 1'b0;
        repeat (12) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
